sha1_wsched: RTL and testbench
==============================

Name: sha1_wsched

Overview:
SHA-1 message-schedule generator. It sits directly upstream of the SHA-1 round stages and supplies the per-round word w.
- Accepts one 512-bit block as 16 serial 32-bit words.
- Then produces W[0]..W[79], one word per advance.
- Reports round index and round group so the controller can select the round stage and feed it w.

Parameters:
- None; widths are fixed by SHA-1 (32-bit words, 16-word window, 80 rounds).

Ports:
- clk      input   1   system clock, all logic on rising edge
- reset    input   1   synchronous, active-high reset
- start    input   1   begin new block; clears load counter and round index
- wr_en    input   1   write strobe for block word (LOAD state only)
- wr_data  input   32  block word, big-endian word order W[0] first
- next     input   1   advance to next round word (RUN state only)
- w        output  32  current schedule word W[t]
- t        output  7   current round index 0..79
- phase    output  2   round group: 0 for t 0-19, 1 for 20-39, 2 for 40-59, 3 for 60-79
- ready    output  1   high in RUN; w is valid
- done     output  1   high in DONE; all 80 words consumed

Behaviour:
- Reset: synchronous, active-high, clk rising edge only. All 16 window registers=0, load count=0, t=0, state=IDLE. Outputs: w=0, t=0, phase=0, ready=0, done=0.
- Storage: 16x32 shift window buf[0..15]. w = buf[0] combinationally in every state.
- States:
  - IDLE: waits for start.
  - LOAD: accepts words.
  - RUN: serves words.
  - DONE: holds.
- start: from any state, the next state is LOAD, load count=0, t=0. The window is not cleared.
- start has priority over wr_en and next in the same cycle.
- LOAD, wr_en=1:
  - Shift: buf[i]<=buf[i+1] for i=0..14, buf[15]<=wr_data, count++.
  - On the 16th write (count 15->16) the next state is RUN with t=0.
  - W[0] appears on w in the cycle after the last write, i.e. 1-cycle latency.
- RUN, next=1:
  - Shift buf[i]<=buf[i+1].
  - buf[15] <= rotl1(buf[13]^buf[8]^buf[2]^buf[0]), which equals W[t+16].
  - t++.
  - The same rule applies for all t; there is no special case for t<16.
- RUN, t=79 with next=1: next state is DONE. The window still shifts, but w in DONE is don't-care for consumers.
  - t saturates at 79 in DONE.
- Ignored strobes (no state change):
  - wr_en outside LOAD.
  - next outside RUN.
  - wr_en and next both asserted in LOAD: only wr_en acts.
- phase: derived combinationally from t (t<20:0, <40:1, <60:2, else 3).
- ready: high only in RUN.
- done: high only in DONE. done stays high until start or reset.
- reset asserted mid-LOAD or mid-RUN: all state returns to reset values on that edge. Partial load is discarded.
- rotl1(x) = {x[30:0], x[31]}. All XOR/rotate are 32-bit with no carries.
- No back-pressure: the consumer pulses next once per round after latching w, t and phase.

Test Plan:
1. Reset then idle:
   - Stimulus: assert reset 2 cycles, release, toggle next and wr_en.
   - Required: w=0, t=0, ready=0, done=0 throughout. State stays IDLE.
2. "abc" padded block:
   - Stimulus: start, then write 0x61626380, fourteen 0x00000000, then 0x00000018.
   - Required: ready rises 1 cycle after the 16th write, with w=0x61626380, t=0.
3. Schedule expansion:
   - Stimulus: continue test 2; pulse next 19 times.
   - Required at t=16: w=0xC2C4C700. t=17: w=0x00000000. t=18: w=0x00000030. t=19: w=0x85898E01.
   - Required: phase=0 through t=19, and phase=1 after the 20th next.
4. Full run:
   - Stimulus: continue to 80 nexts total.
   - Required: phase changes at t=20/40/60. After the 80th next, done=1, ready=0, t=79.
   - Required: extra next pulses change nothing.
5. Gaps and ignored strobes:
   - Stimulus: in LOAD, insert idle cycles between writes, and assert next alongside writes.
   - Required: results identical to test 2, with ready only after exactly 16 wr_en.
   - Stimulus: in RUN, assert wr_en.
   - Required: no effect on w or t.
6. Abort paths:
   - Stimulus: reset asserted after 7 writes.
   - Required: all outputs at reset values; a fresh 16-word load reproduces test 2.
   - Stimulus: start asserted at t=35 in RUN.
   - Required: ready=0 next cycle, t=0, new load accepted.
   - Stimulus: start and next in the same cycle.
   - Required: start wins.

Source files
------------

// File: rtl/sha1_wsched.sv
// sha1_wsched: SHA-1 message-schedule generator.
// Loads one 512-bit block as 16 serial 32-bit words (W[0] first), then
// expands and serves W[0]..W[79], one word per 'next' pulse.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a new block (clears load count and round index)
//   wr_en, wr_data  block word write strobe/data (LOAD only)
//   next            advance to the next round word (RUN only)
//   w               current schedule word W[t] (window head)
//   t, phase        round index 0..79 and round group 0..3
//   ready, done     high in RUN / high in DONE
module sha1_wsched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        next,
  output logic [31:0] w,
  output logic [6:0]  t,
  output logic [1:0]  phase,
  output logic        ready,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} stateT;

  stateT             state, stateNext;
  logic [15:0][31:0] win;      // win[0] is the oldest word, i.e. W[t]
  logic [4:0]        loadCnt;
  logic [6:0]        rnd;
  logic              doWrite, doAdvance;
  logic [31:0]       fbWord, newWord;

  // start overrides any strobe in the same cycle
  assign doWrite   = !start && (state == LOAD) && wr_en;
  assign doAdvance = !start && (state == RUN) && next;

  // W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t])
  assign fbWord  = win[13] ^ win[8] ^ win[2] ^ win[0];
  assign newWord = {fbWord[30:0], fbWord[31]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (start)                                 stateNext = LOAD;
    else if (doWrite && loadCnt == 5'd15)      stateNext = RUN;
    else if (doAdvance && rnd == 7'd79)        stateNext = DONE;
  end

  // Window contents survive start; a full 16-word load replaces them anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      win     <= '0;
      loadCnt <= '0;
      rnd     <= '0;
    end else if (start) begin
      loadCnt <= '0;
      rnd     <= '0;
    end else if (doWrite) begin
      win     <= {wr_data, win[15:1]};
      loadCnt <= loadCnt + 5'd1;
    end else if (doAdvance) begin
      // Final advance still shifts; t saturates at 79 in DONE.
      win <= {newWord, win[15:1]};
      if (rnd != 7'd79) rnd <= rnd + 7'd1;
    end
  end

  assign w     = win[0];
  assign t     = rnd;
  assign phase = (rnd < 7'd20) ? 2'd0 :
                 (rnd < 7'd40) ? 2'd1 :
                 (rnd < 7'd60) ? 2'd2 : 2'd3;
  assign ready = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_sha1_wsched.sv
// Directed bench for sha1_wsched: reset/idle, "abc" block load, schedule
// expansion with hand-computed words, full 80-round run, ignored strobes,
// and abort paths (reset mid-load, start mid-run, start vs next).
module tb_sha1_wsched;

  logic        clk = 1'b0;
  logic        reset, start, wr_en, next;
  logic [31:0] wr_data;
  logic [31:0] w;
  logic [6:0]  t;
  logic [1:0]  phase;
  logic        ready, done;

  int passes = 0;
  int total  = 0;

  logic [31:0] abcBlk [16];
  logic [31:0] wm     [80];

  sha1_wsched dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en),
    .wr_data(wr_data), .next(next), .w(w), .t(t), .phase(phase),
    .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic doStart();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic pulseNext();
    next = 1'b1; tick(); next = 1'b0;
  endtask

  task automatic loadAbc();
    doStart();
    for (int i = 0; i < 16; i++) writeWord(abcBlk[i]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wr_en = 1'b0; next = 1'b0; wr_data = '0;

    for (int i = 0; i < 16; i++) abcBlk[i] = 32'h0;
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;
    // Reference schedule via the textbook recurrence over the full array
    for (int i = 0; i < 16; i++) wm[i] = abcBlk[i];
    for (int i = 16; i < 80; i++) begin
      logic [31:0] x;
      x = wm[i-3] ^ wm[i-8] ^ wm[i-14] ^ wm[i-16];
      wm[i] = {x[30:0], x[31]};
    end

    // 1. reset then idle with stray strobes
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk("rst_w", w, 32'h0);
    chk("rst_t", {25'd0, t}, 32'd0);
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wr_en = i[0]; next = ~i[0]; wr_data = 32'hFFFFFFFF; tick();
    end
    wr_en = 1'b0; next = 1'b0;
    chk("idle_w", w, 32'h0);
    chk("idle_t", {25'd0, t}, 32'd0);
    chk("idle_ready", {31'd0, ready}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // 2. "abc" padded block
    doStart();
    for (int i = 0; i < 15; i++) writeWord(abcBlk[i]);
    chk("load15_ready", {31'd0, ready}, 32'd0);
    writeWord(abcBlk[15]);
    chk("load16_ready", {31'd0, ready}, 32'd1);
    chk("load16_w", w, 32'h61626380);
    chk("load16_t", {25'd0, t}, 32'd0);

    // 3/4. expansion and full run
    for (int k = 1; k <= 80; k++) begin
      pulseNext();
      if (k < 80) begin
        chk("run_w", w, wm[k]);
        chk("run_t", {25'd0, t}, k);
        chk("run_phase", {30'd0, phase}, k / 20);
      end
      if (k == 16) chk("w16", w, 32'hC2C4C700);
      if (k == 17) chk("w17", w, 32'h00000000);
      if (k == 18) chk("w18", w, 32'h00000030);
      if (k == 19) chk("w19", w, 32'h85898E01);
      if (k == 20) chk("phase_t20", {30'd0, phase}, 32'd1);
      if (k == 40) chk("phase_t40", {30'd0, phase}, 32'd2);
      if (k == 60) chk("phase_t60", {30'd0, phase}, 32'd3);
    end
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_ready", {31'd0, ready}, 32'd0);
    chk("end_t", {25'd0, t}, 32'd79);
    for (int i = 0; i < 3; i++) pulseNext();
    chk("extra_done", {31'd0, done}, 32'd1);
    chk("extra_t", {25'd0, t}, 32'd79);

    // 5. gaps and ignored next during LOAD
    doStart();
    chk("restart_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; next = 1'b1; wr_data = abcBlk[i]; tick();
      wr_en = 1'b0; next = 1'b0;
      if (i == 14) chk("gap15_ready", {31'd0, ready}, 32'd0);
      if (i < 15) begin tick(); tick(); end
    end
    chk("gap_ready", {31'd0, ready}, 32'd1);
    chk("gap_w", w, 32'h61626380);
    chk("gap_t", {25'd0, t}, 32'd0);
    writeWord(32'hDEADBEEF);
    chk("run_wr_w", w, 32'h61626380);
    chk("run_wr_t", {25'd0, t}, 32'd0);
    for (int i = 0; i < 16; i++) pulseNext();
    chk("gap_w16", w, 32'hC2C4C700);
    chk("gap_t16", {25'd0, t}, 32'd16);

    // 6a. reset after 7 writes
    doStart();
    for (int i = 0; i < 7; i++) writeWord(32'h11111111 * (i + 1));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_w", w, 32'h0);
    chk("abort_t", {25'd0, t}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    writeWord(32'h12345678);   // IDLE: ignored
    chk("abort_idle_w", w, 32'h0);
    loadAbc();
    chk("reload_ready", {31'd0, ready}, 32'd1);
    chk("reload_w", w, 32'h61626380);

    // 6b. start at t=35
    for (int i = 0; i < 35; i++) pulseNext();
    chk("t35", {25'd0, t}, 32'd35);
    chk("t35_phase", {30'd0, phase}, 32'd1);
    doStart();
    chk("midrun_ready", {31'd0, ready}, 32'd0);
    chk("midrun_t", {25'd0, t}, 32'd0);
    for (int i = 0; i < 16; i++) writeWord(i + 1);
    chk("blk2_ready", {31'd0, ready}, 32'd1);
    chk("blk2_w", w, 32'd1);

    // 6c. start and next together
    pulseNext(); pulseNext();
    chk("blk2_w2", w, 32'd3);
    start = 1'b1; next = 1'b1; tick(); start = 1'b0; next = 1'b0;
    chk("sn_ready", {31'd0, ready}, 32'd0);
    chk("sn_t", {25'd0, t}, 32'd0);
    chk("sn_w", w, 32'd3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
